// File: rtl/count_pkg.sv
// Shared types for the counter event logger: event kinds, tracker states
// and the packed event record stored in the FIFO.
package count_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    EVT_NONE      = 2'd0,
    EVT_UP_WRAP   = 2'd1,
    EVT_DOWN_WRAP = 2'd2,
    EVT_JUMP      = 2'd3
  } evt_kind_e;

  typedef enum logic {
    ST_NO_BASE = 1'b0,
    ST_TRACK   = 1'b1
  } trk_state_e;

  // Record width follows WIDTH_DEF; the logger's WIDTH must match it.
  typedef struct packed {
    evt_kind_e              kind;
    logic [WIDTH_DEF-1:0]   prev;
    logic [WIDTH_DEF-1:0]   value;
  } count_evt_t;
endpackage

// File: rtl/count_evt_fifo.sv
// Synchronous FIFO of count_evt_t records; pointers carry one extra bit so
// full and empty are distinguished without a separate occupancy counter.
module count_evt_fifo
  import count_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  count_evt_t wdata,
  output count_evt_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  count_evt_t  mem [DEPTH];
  logic        pop_ok;

  // Storage is cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign pop_ok = pop && !empty;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head   = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/count_event_logger.sv
// Observes a WIDTH-bit counter, classifies each sampled transition and queues
// wraps and jumps for a valid/ready consumer, with saturating wrap statistics.
module count_event_logger
  import count_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [WIDTH-1:0]  count_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_kind,
  output logic [WIDTH-1:0]  evt_prev,
  output logic [WIDTH-1:0]  evt_value,
  output logic [STAT_W-1:0] up_wraps,
  output logic [STAT_W-1:0] down_wraps,
  output logic              overflow
);
  trk_state_e       state;
  logic [WIDTH-1:0] prev;
  evt_kind_e        kind;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             empty;
  count_evt_t       wdata;
  count_evt_t       head;

  // Wraps are tested before single steps because prev+1 wraps to 0 at max.
  function automatic evt_kind_e classify(input logic [WIDTH-1:0] p,
                                         input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] max_v;
    max_v = '1;
    if (c == p)                                          return EVT_NONE;
    else if ((p == max_v) && (c == '0))                  return EVT_UP_WRAP;
    else if ((p == '0) && (c == max_v))                  return EVT_DOWN_WRAP;
    else if ((c == p + WIDTH'(1)) || (c == p - WIDTH'(1))) return EVT_NONE;
    else                                                 return EVT_JUMP;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    if (v == '1) return v;
    else         return v + STAT_W'(1);
  endfunction

  // Classification, handshake and push acceptance.
  always_comb begin
    kind        = classify(prev, count_in);
    push_req    = sample_en && (state == ST_TRACK) && (kind != EVT_NONE);
    pop         = evt_valid && evt_ready;
    push_ok     = push_req && (!full || pop);
    wdata.kind  = kind;
    wdata.prev  = prev;
    wdata.value = count_in;
  end

  // Baseline tracker, statistics and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_NO_BASE;
      prev       <= '0;
      up_wraps   <= '0;
      down_wraps <= '0;
      overflow   <= 1'b0;
    end else if (sample_en) begin
      case (state)
        ST_NO_BASE: begin
          prev  <= count_in;
          state <= ST_TRACK;
        end
        ST_TRACK: begin
          prev <= count_in;
          if (kind == EVT_UP_WRAP)   up_wraps   <= sat_inc(up_wraps);
          if (kind == EVT_DOWN_WRAP) down_wraps <= sat_inc(down_wraps);
          if (push_req && full && !pop) overflow <= 1'b1;
        end
        default: state <= ST_NO_BASE;
      endcase
    end
  end

  count_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign evt_valid = !empty;
  assign evt_kind  = head.kind;
  assign evt_prev  = head.prev;
  assign evt_value = head.value;
endmodule
